// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } if_state_e;

  localparam logic [63:0] IF_RESET_PC  = 64'h0;
  localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a one-entry skid buffer for responses that
// arrive while decode is stalled.
module if_id_reg
  import if_pkg::*;
#(
  parameter int unsigned              BUS_WIDTH   = 64,
  parameter int unsigned              INSTR_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0]   NOP_INSTR   = INSTR_WIDTH'(IF_NOP_INSTR)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   load_out,
  input  logic                   load_skid,
  input  logic                   skid_to_out,
  input  logic [BUS_WIDTH-1:0]   in_pc,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  output logic                   if_valid,
  output logic [BUS_WIDTH-1:0]   if_pc,
  output logic [INSTR_WIDTH-1:0] if_instr
);

  logic                   valid_q, valid_d;
  logic [BUS_WIDTH-1:0]   pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   skid_valid_q, skid_valid_d;
  logic [BUS_WIDTH-1:0]   skid_pc_q, skid_pc_d;
  logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;

  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    if (flush) begin
      valid_d      = 1'b0;
      instr_d      = NOP_INSTR;
      skid_valid_d = 1'b0;
    end else if (load_out) begin
      valid_d = 1'b1;
      pc_d    = in_pc;
      instr_d = in_instr;
    end else if (skid_to_out && skid_valid_q) begin
      valid_d      = 1'b1;
      pc_d         = skid_pc_q;
      instr_d      = skid_instr_q;
      skid_valid_d = 1'b0;
    end else begin
      if (load_skid) begin
        skid_valid_d = 1'b1;
        skid_pc_d    = in_pc;
        skid_instr_d = in_instr;
      end
      // Decode consumed the current entry and nothing replaces it; pc is kept.
      if (!stall) begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      instr_q      <= NOP_INSTR;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  assign if_valid = valid_q;
  assign if_pc    = pc_q;
  assign if_instr = instr_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request
// at a time and feeds the IF/ID register.
module if_stage
  import if_pkg::*;
#(
  parameter int unsigned            BUS_WIDTH   = 64,
  parameter int unsigned            INSTR_WIDTH = 32,
  parameter logic [BUS_WIDTH-1:0]   RESET_PC    = BUS_WIDTH'(IF_RESET_PC),
  parameter int unsigned            PC_INCR     = 4,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(IF_NOP_INSTR)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [BUS_WIDTH-1:0]   redirect_pc,
  output logic                   imem_req,
  output logic [BUS_WIDTH-1:0]   imem_addr,
  input  logic                   imem_ready,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   if_valid,
  output logic [BUS_WIDTH-1:0]   if_pc,
  output logic [INSTR_WIDTH-1:0] if_instr
);

  if_state_e            state_q, state_d;
  logic [BUS_WIDTH-1:0] pc_q, pc_d;
  logic [BUS_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                 drop_q, drop_d;
  logic                 imem_req_q, imem_req_d;
  logic                 load_out, load_skid, skid_to_out;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    drop_d      = drop_q;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;

    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ready) begin
          req_pc_d = pc_q;
          state_d  = WAIT;
          // A request accepted in the redirect cycle is already committed.
          if (redirect) drop_d = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          drop_d = 1'b0;
          if (drop_q || redirect) begin
            state_d = FETCH;
          end else begin
            pc_d = req_pc_q + BUS_WIDTH'(PC_INCR);
            if (!if_valid || !stall) begin
              load_out = 1'b1;
              state_d  = FETCH;
            end else begin
              load_skid = 1'b1;
              state_d   = HOLD;
            end
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (!stall) begin
          skid_to_out = 1'b1;
          state_d     = FETCH;
        end
      end
    endcase

    if (redirect) begin
      pc_d        = redirect_pc;
      load_out    = 1'b0;
      load_skid   = 1'b0;
      skid_to_out = 1'b0;
      if (state_q == HOLD) state_d = FETCH;
    end

    imem_req_d = (state_d == FETCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      drop_q     <= 1'b0;
      imem_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      drop_q     <= drop_d;
      imem_req_q <= imem_req_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;

  if_id_reg #(
    .BUS_WIDTH   (BUS_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH),
    .NOP_INSTR   (NOP_INSTR)
  ) u_if_id_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (redirect),
    .load_out    (load_out),
    .load_skid   (load_skid),
    .skid_to_out (skid_to_out),
    .in_pc       (req_pc_q),
    .in_instr    (imem_rdata),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr)
  );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed pipeline scenarios plus a randomized run
// checked against an in-order program-stream model.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;

  int checks = 0;
  int errors = 0;

  int          rdy_mode;
  int          mem_lat;
  logic [31:0] mem_xor;
  logic        pend;
  logic [63:0] pend_addr;
  int          pend_cnt;

  if_stage #(
    .BUS_WIDTH   (64),
    .INSTR_WIDTH (32),
    .RESET_PC    (64'h0),
    .PC_INCR     (4),
    .NOP_INSTR   (NOP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ mem_xor;
  endfunction

  // Memory model: decides inputs for the coming rising edge from outputs seen now.
  task automatic mem_update();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (pend) begin
      if (pend_cnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pend        = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    case (rdy_mode)
      0:       imem_ready = 1'b0;
      1:       imem_ready = 1'b1;
      default: imem_ready = ($urandom_range(0, 2) != 0);
    endcase
    if (imem_req && imem_ready) begin
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_cnt  = (mem_lat > 0) ? mem_lat : int'($urandom_range(1, 3));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mem_update();
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    pend        = 1'b0;
    rdy_mode    = 1;
    mem_lat     = 1;
    mem_xor     = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    mem_update();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if_valid); end
    checks++; if (if_pc !== 64'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", if_pc); end
    checks++; if (if_instr !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", if_instr, NOP); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    release_reset();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL dead_cycle_req got %b exp 0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      errors++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic test_zero_wait();
    apply_reset();
    release_reset();
    repeat (2) begin
      tick();
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL zw_early_valid got %b exp 0", if_valid); end
    end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 64'h0 || if_instr !== 32'h0) begin
      errors++; $display("FAIL zw_first got v=%b pc=%h i=%h exp v=1 pc=0 i=0", if_valid, if_pc, if_instr);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL zw_gap%0d got %b exp 0", k, if_valid); end
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== 64'(4 * k) || if_instr !== 32'(4 * k)) begin
        errors++; $display("FAIL zw_seq%0d got v=%b pc=%h i=%h exp pc=%h", k, if_valid, if_pc, if_instr, 4 * k);
      end
    end
  endtask

  task automatic test_ready_low();
    bit got;
    apply_reset();
    rdy_mode = 0;
    release_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
        errors++; $display("FAIL rdy_hold%0d got req=%b addr=%h exp req=1 addr=0", i, imem_req, imem_addr);
      end
    end
    rdy_mode = 1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      got = if_valid;
    end
    checks++; if (!got || if_pc !== 64'h0 || if_instr !== 32'h0) begin
      errors++; $display("FAIL rdy_resume got v=%b pc=%h i=%h exp v=1 pc=0 i=0", got, if_pc, if_instr);
    end
  endtask

  // Brings the pipe to: output holds 0x4, response for 0x8 in the skid, stall high.
  task automatic reach_hold();
    apply_reset();
    release_reset();
    repeat (5) tick();
    stall = 1'b1;
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 64'h4) begin
      errors++; $display("FAIL stall_hold got v=%b pc=%h exp v=1 pc=4", if_valid, if_pc);
    end
    tick();
  endtask

  task automatic test_stall_skid();
    reach_hold();
    repeat (2) begin
      checks++; if (if_valid !== 1'b1 || if_pc !== 64'h4 || if_instr !== 32'h4 || imem_req !== 1'b0) begin
        errors++; $display("FAIL skid_hold got v=%b pc=%h i=%h req=%b exp v=1 pc=4 i=4 req=0",
                           if_valid, if_pc, if_instr, imem_req);
      end
      tick();
    end
    stall = 1'b0;
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 64'h8 || if_instr !== 32'h8) begin
      errors++; $display("FAIL skid_release got v=%b pc=%h i=%h exp pc=8", if_valid, if_pc, if_instr);
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'hC) begin
      errors++; $display("FAIL skid_next_req got req=%b addr=%h exp addr=c", imem_req, imem_addr);
    end
    tick();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL skid_no_dup got %b exp 0", if_valid); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 64'hC) begin
      errors++; $display("FAIL skid_after got v=%b pc=%h exp pc=c", if_valid, if_pc);
    end
  endtask

  task automatic test_redirect_skid();
    reach_hold();
    tick();
    redirect    = 1'b1;
    redirect_pc = 64'h200;
    tick();
    redirect = 1'b0;
    checks++; if (if_valid !== 1'b0 || if_instr !== NOP) begin
      errors++; $display("FAIL rs_flush got v=%b i=%h exp v=0 i=%h", if_valid, if_instr, NOP);
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h200) begin
      errors++; $display("FAIL rs_req got req=%b addr=%h exp addr=200", imem_req, imem_addr);
    end
    tick();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rs_skid_cleared got %b exp 0", if_valid); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 64'h200 || if_instr !== 32'h200) begin
      errors++; $display("FAIL rs_target got v=%b pc=%h i=%h exp pc=200", if_valid, if_pc, if_instr);
    end
    stall = 1'b0;
  endtask

  task automatic test_redirect_wait();
    apply_reset();
    mem_lat = 3;
    release_reset();
    repeat (2) tick();
    redirect    = 1'b1;
    redirect_pc = 64'h100;
    tick();
    redirect = 1'b0;
    mem_lat  = 1;
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL rw_wait got v=%b req=%b exp 0 0", if_valid, imem_req);
    end
    tick();
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h100 || if_valid !== 1'b0) begin
      errors++; $display("FAIL rw_refetch got req=%b addr=%h v=%b exp req=1 addr=100 v=0", imem_req, imem_addr, if_valid);
    end
    tick();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rw_dropped got %b exp 0", if_valid); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 64'h100 || if_instr !== 32'h100) begin
      errors++; $display("FAIL rw_target got v=%b pc=%h i=%h exp pc=100", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_reset_midwait();
    bit got;
    apply_reset();
    mem_lat = 3;
    release_reset();
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
      errors++; $display("FAIL rm_async got req=%b v=%b exp 0 0", imem_req, if_valid);
    end
    @(negedge clk);
    rst_n       = 1'b1;
    pend        = 1'b0;
    rdy_mode    = 0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0 || if_valid !== 1'b0) begin
      errors++; $display("FAIL rm_stale got req=%b addr=%h v=%b exp req=1 addr=0 v=0", imem_req, imem_addr, if_valid);
    end
    rdy_mode = 1;
    mem_lat  = 1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      got = if_valid;
    end
    checks++; if (!got || if_pc !== 64'h0 || if_instr !== 32'h0) begin
      errors++; $display("FAIL rm_restart got v=%b pc=%h i=%h exp v=1 pc=0 i=0", got, if_pc, if_instr);
    end
  endtask

  // Program-order model: delivered PCs run +4 from reset or the last redirect target.
  task automatic test_random();
    logic [63:0] exp_pc, prev_addr;
    logic        prev_req, prev_ready, prev_redirect;
    int          idle;
    apply_reset();
    rdy_mode = 2;
    mem_lat  = 0;
    mem_xor  = $urandom;
    release_reset();
    exp_pc        = 64'h0;
    idle          = 0;
    prev_req      = imem_req;
    prev_ready    = imem_ready;
    prev_redirect = 1'b0;
    prev_addr     = imem_addr;
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (prev_req && !prev_ready && !prev_redirect) begin
        checks++; if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
          errors++; $display("FAIL rnd_addr_stable got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, prev_addr);
        end
      end
      checks++;
      if (if_valid) begin
        if (if_instr !== mem_word(if_pc)) begin
          errors++; $display("FAIL rnd_instr got %h exp %h at pc %h", if_instr, mem_word(if_pc), if_pc);
        end
      end else if (if_instr !== NOP) begin
        errors++; $display("FAIL rnd_nop got %h exp %h", if_instr, NOP);
      end
      stall    = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
      else                           redirect_pc = {$urandom, $urandom};
      if (if_valid && !stall) begin
        checks++; if (if_pc !== exp_pc) begin
          errors++; $display("FAIL rnd_order got pc=%h exp pc=%h", if_pc, exp_pc);
        end
        exp_pc = exp_pc + 64'd4;
        idle   = 0;
      end else begin
        idle++;
      end
      if (redirect) exp_pc = redirect_pc;
      if (idle > 200) begin
        checks++; errors++;
        $display("FAIL rnd_progress got %0d idle cycles exp at most 200", idle);
        break;
      end
      prev_req      = imem_req;
      prev_ready    = imem_ready;
      prev_redirect = redirect;
      prev_addr     = imem_addr;
    end
    stall    = 1'b0;
    redirect = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_zero_wait();
    test_ready_low();
    test_stall_skid();
    test_redirect_skid();
    test_redirect_wait();
    test_reset_midwait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
